// File: rtl/sst_walker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sst_walker                                                    |
// | Purpose  : Save-state initiator that dumps/restores mapper registers     |
// |            over the sst bus. Optional checksum byte via SST_CRC_EN.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sst_walker #(
    parameter int REG_CNT     = 128,
    parameter int RD_SETTLE   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       cpu_m2,
    input  logic       cmd_dump,
    input  logic       cmd_load,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sst_act,
    output logic       sst_we_reg,
    output logic [7:0] sst_addr,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int c_cnt_max = (RD_SETTLE > SYNC_STAGES) ? RD_SETTLE : SYNC_STAGES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1) + 1;

    localparam logic [7:0]         c_last_addr  = 8'(REG_CNT - 1);
    localparam logic [c_cnt_w-1:0] c_settle_end = c_cnt_w'(RD_SETTLE - 1);
    localparam logic [c_cnt_w-1:0] c_guard      = c_cnt_w'(SYNC_STAGES);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_wait = 3'd1;
    localparam logic [2:0] c_st_tx      = 3'd2;
    localparam logic [2:0] c_st_rx      = 3'd3;
    localparam logic [2:0] c_st_wr_hold = 3'd4;
    localparam logic [2:0] c_st_crc_tx  = 3'd5;
    localparam logic [2:0] c_st_crc_rx  = 3'd6;
    localparam logic [2:0] c_st_fin     = 3'd7;

    logic [2:0]             r_state, w_state_nxt;
    logic [7:0]             r_addr, w_addr_nxt;
    logic [7:0]             r_dato, w_dato_nxt;
    logic                   r_we, w_we_nxt;
    logic [7:0]             r_txd, w_txd_nxt;
    logic                   r_txv, w_txv_nxt;
    logic                   r_rxr, w_rxr_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_m2_sync;
    logic                   r_m2_prev;
    logic                   w_m2_fall;
    logic                   w_tx_hs;
    logic                   w_rx_hs;
    logic                   w_finish;
`ifdef SST_CRC_EN
    logic [7:0]             r_sum, w_sum_nxt;
    logic                   r_err, w_err_nxt;
`endif

    assign w_m2_fall = r_m2_prev & ~r_m2_sync[SYNC_STAGES-1];
    assign w_tx_hs   = r_txv & tx_ready;
    assign w_rx_hs   = r_rxr & rx_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_dato_nxt  = r_dato;
        w_we_nxt    = r_we;
        w_txd_nxt   = r_txd;
        w_txv_nxt   = r_txv;
        w_rxr_nxt   = r_rxr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_finish    = 1'b0;
`ifdef SST_CRC_EN
        w_sum_nxt   = r_sum;
        w_err_nxt   = r_err;
`endif

        case (r_state)
            c_st_idle: begin
                if (cmd_dump || cmd_load) begin
                    w_addr_nxt = 8'd0;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = '0;
`ifdef SST_CRC_EN
                    w_sum_nxt  = 8'd0;
                    w_err_nxt  = 1'b0;
`endif
                    if (cmd_dump) begin
                        w_state_nxt = c_st_rd_wait;
                    end else begin
                        w_state_nxt = c_st_rx;
                        w_rxr_nxt   = 1'b1;
                    end
                end
            end

            c_st_rd_wait: begin
                if (r_cnt == c_settle_end) begin
                    w_txd_nxt   = sst_di;
                    w_txv_nxt   = 1'b1;
                    w_state_nxt = c_st_tx;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            c_st_tx: begin
                if (w_tx_hs) begin
                    w_txv_nxt = 1'b0;
`ifdef SST_CRC_EN
                    w_sum_nxt = r_sum + r_txd;
`endif
                    if (r_addr == c_last_addr) begin
`ifdef SST_CRC_EN
                        // Checksum byte makes the sum of all emitted bytes zero
                        w_txd_nxt   = 8'd0 - (r_sum + r_txd);
                        w_txv_nxt   = 1'b1;
                        w_state_nxt = c_st_crc_tx;
`else
                        w_finish    = 1'b1;
`endif
                    end else begin
                        w_addr_nxt  = r_addr + 8'd1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_st_rd_wait;
                    end
                end
            end

            c_st_rx: begin
                if (w_rx_hs) begin
                    w_rxr_nxt   = 1'b0;
                    w_dato_nxt  = rx_data;
                    w_we_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_wr_hold;
`ifdef SST_CRC_EN
                    w_sum_nxt   = r_sum + rx_data;
`endif
                end
            end

            c_st_wr_hold: begin
                // Ignore falls whose sampled 1->0 pair predates the write strobe
                if (r_cnt != c_guard) begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end else if (w_m2_fall) begin
                    w_we_nxt = 1'b0;
                    if (r_addr == c_last_addr) begin
`ifdef SST_CRC_EN
                        w_rxr_nxt   = 1'b1;
                        w_state_nxt = c_st_crc_rx;
`else
                        w_finish    = 1'b1;
`endif
                    end else begin
                        w_addr_nxt  = r_addr + 8'd1;
                        w_rxr_nxt   = 1'b1;
                        w_state_nxt = c_st_rx;
                    end
                end
            end

`ifdef SST_CRC_EN
            c_st_crc_tx: begin
                if (w_tx_hs) begin
                    w_txv_nxt = 1'b0;
                    w_finish  = 1'b1;
                end
            end

            c_st_crc_rx: begin
                if (w_rx_hs) begin
                    w_rxr_nxt = 1'b0;
                    w_err_nxt = ((r_sum + rx_data) != 8'd0);
                    w_finish  = 1'b1;
                end
            end
`endif

            c_st_fin: begin
                w_state_nxt = c_st_idle;
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        if (w_finish) begin
            w_state_nxt = c_st_fin;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_addr_nxt  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_state   <= c_st_idle;
            r_addr    <= 8'd0;
            r_dato    <= 8'd0;
            r_we      <= 1'b0;
            r_txd     <= 8'd0;
            r_txv     <= 1'b0;
            r_rxr     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_m2_sync <= '0;
            r_m2_prev <= 1'b0;
`ifdef SST_CRC_EN
            r_sum     <= 8'd0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_dato    <= w_dato_nxt;
            r_we      <= w_we_nxt;
            r_txd     <= w_txd_nxt;
            r_txv     <= w_txv_nxt;
            r_rxr     <= w_rxr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_cnt     <= w_cnt_nxt;
            r_m2_sync <= {r_m2_sync[SYNC_STAGES-2:0], cpu_m2};
            r_m2_prev <= r_m2_sync[SYNC_STAGES-1];
`ifdef SST_CRC_EN
            r_sum     <= w_sum_nxt;
            r_err     <= w_err_nxt;
`endif
        end
    end

    assign busy       = r_busy;
    assign sst_act    = r_busy;
    assign done       = r_done;
    assign sst_we_reg = r_we;
    assign sst_addr   = r_addr;
    assign sst_dato   = r_dato;
    assign tx_data    = r_txd;
    assign tx_valid   = r_txv;
    assign rx_ready   = r_rxr;
`ifdef SST_CRC_EN
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sst_walker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sst_walker                                                 |
// | Purpose  : Self-checking bench for sst_walker (dump, restore, reset,     |
// |            command arbitration, checksum when SST_CRC_EN is defined).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sst_walker;

    localparam int REG_CNT     = 128;
    localparam int RD_SETTLE   = 2;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       map_rst = 1'b1;
    logic       cpu_m2 = 1'b0;
    logic       cmd_dump = 1'b0;
    logic       cmd_load = 1'b0;
    logic       busy, done, err, sst_act, sst_we_reg;
    logic [7:0] sst_addr, sst_dato, sst_di, tx_data;
    logic       tx_valid, rx_ready;
    logic       tx_ready = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    sst_walker #(
        .REG_CNT     (REG_CNT),
        .RD_SETTLE   (RD_SETTLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .map_rst    (map_rst),
        .cpu_m2     (cpu_m2),
        .cmd_dump   (cmd_dump),
        .cmd_load   (cmd_load),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sst_act    (sst_act),
        .sst_we_reg (sst_we_reg),
        .sst_addr   (sst_addr),
        .sst_dato   (sst_dato),
        .sst_di     (sst_di),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Mapper side: readback array and write capture on the real M2 falling edge
    logic [7:0] di_mem  [256];
    logic [7:0] ld_mem  [256];
    logic [7:0] map_mem [256];
    int         wins;
    bit         m2_run = 1'b0;

    assign sst_di = di_mem[sst_addr];

    initial begin
        #3;
        forever begin
            if (m2_run) begin
                cpu_m2 = 1'b1; #60;
                cpu_m2 = 1'b0; #60;
            end else begin
                #10;
            end
        end
    end

    always @(negedge cpu_m2) begin
        if (sst_we_reg) begin
            map_mem[sst_addr] = sst_dato;
            wins++;
        end
    end

    // Sink readiness: bursts of random level, each at most 20 cycles long
    bit rand_ready = 1'b0;
    int run_len = 0;
    always @(posedge clk) begin
        #1;
        if (!rand_ready) begin
            tx_ready = 1'b1;
        end else begin
            if (run_len == 0) begin
                tx_ready = 1'($urandom_range(0, 1));
                run_len  = int'($urandom_range(1, 20));
            end
            run_len--;
        end
    end

    logic [7:0] rx_feed [$];
    always @(posedge clk) begin
        bit hs;
        hs = rx_valid && rx_ready;
        #1;
        if (hs && rx_feed.size() > 0) void'(rx_feed.pop_front());
        rx_valid = (rx_feed.size() > 0);
        rx_data  = rx_valid ? rx_feed[0] : 8'h00;
    end

    // Observers sampled on the falling clock edge
    logic [7:0] tx_q [$];
    int         hs_cyc [$];
    int         cyc = 0;
    int         done_cnt, done_bad, stall_bad, rxr_bad, we_rises;
    bit         dump_mode = 1'b0;
    bit         prev_stall = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, prev_we = 1'b0;
    logic [7:0] prev_txd = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            tx_q.push_back(tx_data);
            hs_cyc.push_back(cyc);
        end
        if (prev_stall && (!tx_valid || tx_data !== prev_txd)) stall_bad++;
        prev_stall = tx_valid && !tx_ready;
        prev_txd   = tx_data;
        if (done) begin
            done_cnt++;
            if (busy || sst_act || !prev_busy || prev_done) done_bad++;
        end
        prev_busy = busy;
        prev_done = done;
        if (sst_we_reg && !prev_we) we_rises++;
        prev_we = sst_we_reg;
        if (dump_mode && rx_ready) rxr_bad++;
    end

    function automatic logic [30:0] outs();
        return {busy, done, err, sst_act, sst_we_reg, sst_addr, sst_dato, tx_data, tx_valid, rx_ready};
    endfunction

    function automatic logic [7:0] model_crc(input bit from_ld);
        logic [7:0] s = 8'h00;
        for (int a = 0; a < REG_CNT; a++) s = s + (from_ld ? ld_mem[a] : di_mem[a]);
        return 8'h00 - s;
    endfunction

    task automatic start_cmd(input bit d, input bit l);
        tx_q.delete();
        hs_cyc.delete();
        done_cnt = 0; done_bad = 0; stall_bad = 0; rxr_bad = 0; wins = 0; we_rises = 0;
        cmd_dump = d;
        cmd_load = l;
        @(posedge clk); #1;
        cmd_dump = 1'b0;
        cmd_load = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Reference: a dump emits readback bytes 0..REG_CNT-1 in order, then the checksum
    task automatic finish_dump(input string name, input bit rnd);
        logic [7:0] exp [$];
        int mism = 0;
        int gaps = 0;
        for (int a = 0; a < REG_CNT; a++) exp.push_back(di_mem[a]);
`ifdef SST_CRC_EN
        exp.push_back(model_crc(1'b0));
`endif
        wait_done(name, 20000);
        chk({name, "_len"}, 32'(tx_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < tx_q.size(); i++)
            if (tx_q[i] !== exp[i]) mism++;
        chk({name, "_data"}, 32'(mism), 32'd0);
        chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({name, "_done_flags"}, 32'(done_bad), 32'd0);
        chk({name, "_stable"}, 32'(stall_bad), 32'd0);
        chk({name, "_no_rx_ready"}, 32'(rxr_bad), 32'd0);
        if (!rnd) begin
            for (int i = 0; i + 1 < REG_CNT && i + 1 < hs_cyc.size(); i++)
                if (hs_cyc[i+1] - hs_cyc[i] != RD_SETTLE + 1) gaps++;
            chk({name, "_spacing"}, 32'(gaps), 32'd0);
        end
        rand_ready = 1'b0;
        dump_mode  = 1'b0;
    endtask

    task automatic run_load(input string name, input logic [7:0] crc_byte);
        int mism = 0;
        for (int a = 0; a < 256; a++) map_mem[a] = 8'hxx;
        rx_feed.delete();
        for (int a = 0; a < REG_CNT; a++) rx_feed.push_back(ld_mem[a]);
        rx_feed.push_back(crc_byte);
        m2_run = 1'b1;
        start_cmd(1'b0, 1'b1);
        wait_done(name, 8000);
        m2_run = 1'b0;
        for (int a = 0; a < REG_CNT; a++)
            if (map_mem[a] !== ld_mem[a]) mism++;
        chk({name, "_windows"}, 32'(wins), 32'(REG_CNT));
        chk({name, "_we_pulses"}, 32'(we_rises), 32'(REG_CNT));
        chk({name, "_mapper_data"}, 32'(mism), 32'd0);
        chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({name, "_done_flags"}, 32'(done_bad), 32'd0);
`ifdef SST_CRC_EN
        chk({name, "_bytes_left"}, 32'(rx_feed.size()), 32'd0);
`else
        chk({name, "_bytes_left"}, 32'(rx_feed.size()), 32'd1);
`endif
    endtask

    typedef struct {
        logic [7:0] key;
        bit         rnd;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [7:0] f, l;
        int n;

        tbl[0] = '{key: 8'h5A, rnd: 1'b0, first: 8'h5A, last: 8'h25};
        tbl[1] = '{key: 8'h5A, rnd: 1'b1, first: 8'h5A, last: 8'h25};
        tbl[2] = '{key: 8'h00, rnd: 1'b1, first: 8'h00, last: 8'h7F};
        tbl[3] = '{key: 8'hFF, rnd: 1'b1, first: 8'hFF, last: 8'h80};
        tbl[4] = '{key: 8'hC3, rnd: 1'b0, first: 8'hC3, last: 8'hBC};

        for (int a = 0; a < 256; a++) begin
            di_mem[a] = 8'h00;
            ld_mem[a] = 8'h00;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        map_rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 32'(outs()), 32'd0);

        // Dump table: address-xor patterns, fixed and random sink readiness
        for (int t = 0; t < 5; t++) begin
            for (int a = 0; a < 256; a++) di_mem[a] = 8'(a) ^ tbl[t].key;
            rand_ready = tbl[t].rnd;
            dump_mode  = 1'b1;
            start_cmd(1'b1, 1'b0);
            finish_dump($sformatf("dump%0d", t), tbl[t].rnd);
            f = 8'hxx;
            l = 8'hxx;
            if (tx_q.size() >= REG_CNT) begin
                f = tx_q[0];
                l = tx_q[REG_CNT-1];
            end
            chk($sformatf("dump%0d_first", t), 32'(f), 32'(tbl[t].first));
            chk($sformatf("dump%0d_last", t), 32'(l), 32'(tbl[t].last));
        end

        for (int a = 0; a < 256; a++) di_mem[a] = 8'($urandom);
        rand_ready = 1'b1;
        dump_mode  = 1'b1;
        start_cmd(1'b1, 1'b0);
        finish_dump("dump_rand", 1'b1);

        for (int a = 0; a < 256; a++) ld_mem[a] = 8'hFF - 8'(a);
        run_load("load_ff", model_crc(1'b1));
        chk("load_err_clean", 32'(err), 32'd0);

        for (int a = 0; a < 256; a++) ld_mem[a] = 8'($urandom);
        run_load("load_rand", model_crc(1'b1));

        // Simultaneous commands start a dump; a later load pulse is ignored
        for (int a = 0; a < 256; a++) di_mem[a] = 8'(a) ^ 8'h6C;
        dump_mode = 1'b1;
        start_cmd(1'b1, 1'b1);
        @(negedge clk);
        chk("both_cmd_dump_wins", 32'({busy, sst_act, rx_ready}), 32'b110);
        repeat (30) @(posedge clk); #1;
        cmd_load = 1'b1;
        @(posedge clk); #1;
        cmd_load = 1'b0;
        finish_dump("both_cmd", 1'b0);

        // Reset in the middle of a restore write
        for (int a = 0; a < 256; a++) ld_mem[a] = 8'($urandom);
        rx_feed.delete();
        for (int a = 0; a < REG_CNT; a++) rx_feed.push_back(ld_mem[a]);
        m2_run = 1'b1;
        start_cmd(1'b0, 1'b1);
        n = 0;
        while (!(sst_we_reg && sst_addr == 8'd40) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_addr40", 32'(sst_we_reg && sst_addr == 8'd40), 32'd1);
        map_rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_outputs", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        map_rst = 1'b0;
        m2_run  = 1'b0;
        rx_feed.delete();
        repeat (6) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        for (int a = 0; a < 256; a++) di_mem[a] = 8'(a) + 8'h11;
        dump_mode = 1'b1;
        start_cmd(1'b1, 1'b0);
        @(negedge clk);
        chk("rst_restart_addr0", 32'({busy, sst_addr}), 32'h100);
        finish_dump("rst_dump", 1'b0);

`ifdef SST_CRC_EN
        for (int a = 0; a < 256; a++) di_mem[a] = 8'h01;
        dump_mode = 1'b1;
        start_cmd(1'b1, 1'b0);
        finish_dump("crc_dump", 1'b0);
        f = 8'hxx;
        if (tx_q.size() > REG_CNT) f = tx_q[REG_CNT];
        chk("crc_dump_byte", 32'(f), 32'h80);

        for (int a = 0; a < 256; a++) ld_mem[a] = 8'h01;
        run_load("crc_bad", 8'h81);
        chk("crc_bad_err", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        chk("crc_err_sticky", 32'(err), 32'd1);
        rx_feed.delete();
        for (int a = 0; a < REG_CNT; a++) rx_feed.push_back(ld_mem[a]);
        rx_feed.push_back(8'h80);
        m2_run = 1'b1;
        start_cmd(1'b0, 1'b1);
        @(negedge clk);
        chk("crc_err_cleared", 32'(err), 32'd0);
        wait_done("crc_good", 8000);
        m2_run = 1'b0;
        chk("crc_good_err", 32'(err), 32'd0);
`else
        chk("err_tied_low", 32'(err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
